// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CPU/debug memory port arbiter: FSM encoding, grant ids
// and the round-robin pick function.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  // One-hot grant, bit 0 = CPU, bit 1 = DBG; a tie goes to whoever was not served last.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] g;
    if (req == 2'b11) g = (last_grant == GNT_DBG) ? 2'b01 : 2'b10;
    else              g = req;
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin arbiter; remembers the last granted requester so that
// continuous contention alternates between the two ports.
module mem_rr_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt          = rr_pick(req, last_grant_q);
    last_grant_d = last_grant_q;
    if (grant_en && (req != 2'b00)) last_grant_d = gnt[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= GNT_DBG;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug accesses onto one fixed-latency synchronous memory.
// Handshake: a requester holds req and its fields until its one-cycle ready pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output arb_state_e        state_dbg
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              grant_en;
  logic [1:0]        gnt_vec;

  mem_rr_arbiter u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      ({dbg_req, cpu_req}),
    .grant_en (grant_en),
    .gnt      (gnt_vec)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    grant_en   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        grant_en = 1'b1;
        if (gnt_vec != 2'b00) begin
          gnt_d   = gnt_vec[1];
          we_d    = gnt_vec[1] ? dbg_we    : cpu_we;
          addr_d  = gnt_vec[1] ? dbg_addr  : cpu_addr;
          wdata_d = gnt_vec[1] ? dbg_wdata : cpu_wdata;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          // Write completions keep the last read data visible on *_rdata.
          if (!we_q) rsp_data_d = mem_rdata;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      gnt_q      <= GNT_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Memory side is driven purely from state and latches, never from live requests.
  assign mem_en    = (state_q == ARB_ACCESS);
  assign mem_we    = (state_q == ARB_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ready = (state_q == ARB_RESP) && (gnt_q == GNT_CPU);
  assign dbg_ready = (state_q == ARB_RESP) && (gnt_q == GNT_DBG);
  assign cpu_rdata = rsp_data_q;
  assign dbg_rdata = rsp_data_q;
  assign busy      = (state_q != ARB_IDLE);
  assign state_dbg = state_q;

endmodule
